// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
//   OVERSAMPLE        : sample ticks per bit (fixed at 16)
//   DATA_BITS         : payload bits per frame
//   SAMPLE_MID_*      : sample indices used for the mid-bit majority vote
//   SAMPLE_LAST       : last sample index of a bit period
//   rx_state_e        : receiver FSM states
//   calc_div()        : clocks per sample tick, integer truncation
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] SAMPLE_MID_LO = 4'd7;
  localparam logic [3:0] SAMPLE_MID    = 4'd8;
  localparam logic [3:0] SAMPLE_MID_HI = 4'd9;
  localparam logic [3:0] SAMPLE_LAST   = 4'd15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per sample tick. The result must be at least 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_band_gen.sv
// Sample-tick generator for the UART receiver.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clear : restarts the period; the first tick follows DIV clocks later
//   tick  : one-clk pulse every DIV clocks
module uart_rx_band_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Masking with clear keeps the tick out of the clear cycle itself, so the
  // first tick after a clear lands exactly DIV clocks later (also for DIV=1).
  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_module.sv
// UART 8N1 receiver, 16x oversampling with mid-bit majority vote.
//   clk             : system clock
//   rst             : asynchronous active-low reset
//   rx_pin_in       : serial line, idles high, asynchronous to clk
//   rx_buf_not_full : receive buffer can accept a byte (looked at only when
//                     the stop bit is evaluated)
//   rx_data         : last good byte, valid while rx_write_buf is high
//   rx_write_buf    : one-clk write strobe into the receive buffer
//   rx_frame_err    : one-clk pulse, stop bit sampled low
//   rx_overrun      : one-clk pulse, good byte dropped (buffer full)
// Write handshake: a byte is transferred on every clock where rx_write_buf is
// high; the buffer has no way to stall it, so rx_buf_not_full must describe
// the buffer's state on that cycle, otherwise the byte is reported as overrun.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin_in,
  input  logic       rx_buf_not_full,
  output logic [7:0] rx_data,
  output logic       rx_write_buf,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // FSM state is a named signal so checkers can bind to it directly.
  rx_state_e  state;
  logic       sync_1, sync_2, sync_3;
  logic       fall;
  logic       clear;
  logic       tick;
  logic [3:0] sample_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       vote_lo, vote_mid;
  logic       vote;
  logic       in_frame;

  uart_rx_band_gen #(.DIV(DIV)) u_band_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  // Two flops for metastability, a third to detect the falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
      sync_3 <= 1'b1;
    end else begin
      sync_1 <= rx_pin_in;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign fall     = sync_3 && !sync_2;
  assign clear    = (state == IDLE) && fall;
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);

  // Sample 9 is the live line; samples 7 and 8 were captured on earlier ticks.
  assign vote = (vote_lo && vote_mid) || (vote_lo && sync_2) || (vote_mid && sync_2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= 4'd0;
      vote_lo    <= 1'b0;
      vote_mid   <= 1'b0;
    end else if (clear) begin
      sample_cnt <= 4'd0;
    end else if (in_frame && tick) begin
      sample_cnt <= sample_cnt + 4'd1;
      if (sample_cnt == SAMPLE_MID_LO) vote_lo  <= sync_2;
      if (sample_cnt == SAMPLE_MID)    vote_mid <= sync_2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      rx_data      <= 8'h00;
      rx_write_buf <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_write_buf <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            bit_idx <= 3'd0;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            // A start bit that reads high mid-bit was only a glitch.
            if ((sample_cnt == SAMPLE_MID_HI) && vote) begin
              state <= IDLE;
            end else if (sample_cnt == SAMPLE_LAST) begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sample_cnt == SAMPLE_MID_HI) begin
              shift_reg[bit_idx] <= vote;
            end else if (sample_cnt == SAMPLE_LAST) begin
              if (bit_idx == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
        end
        STOP: begin
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
          if (tick && (sample_cnt == SAMPLE_MID_HI)) begin
            if (vote) begin
              if (rx_buf_not_full) begin
                rx_data      <= shift_reg;
                rx_write_buf <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A break or stuck-low line must return high before a new start.
          if (sync_2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
module tb_uart_rx_module;
  import uart_pkg::*;

  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_FERR  = 2'd2;
  localparam logic [1:0] K_OVR   = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin_in;
  logic       rx_buf_not_full;
  logic [7:0] rx_data;
  logic       rx_write_buf;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_write_cyc = 0;
  logic [9:0] exp_q[$];

  // DIV = 1_600_000 / (100_000 * 16) = 1, so one bit is 16 clocks.
  uart_rx_module #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_pin_in       (rx_pin_in),
    .rx_buf_not_full (rx_buf_not_full),
    .rx_data         (rx_data),
    .rx_write_buf    (rx_write_buf),
    .rx_frame_err    (rx_frame_err),
    .rx_overrun      (rx_overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    rx_pin_in = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic nf);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    rx_buf_not_full = nf;
    drive_bit(stop_val);
    rx_buf_not_full = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [1:0] k;
    logic [9:0] act;
    logic [9:0] e;
    if (rst && (rx_write_buf || rx_frame_err || rx_overrun)) begin
      check("pulse_exclusive", 32'(rx_write_buf) + 32'(rx_frame_err) + 32'(rx_overrun), 32'd1);
      k   = rx_write_buf ? K_WRITE : (rx_frame_err ? K_FERR : K_OVR);
      act = {k, rx_write_buf ? rx_data : 8'h00};
      if (rx_write_buf) last_write_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got %0h required none", act);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", 32'(act), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int fall_cyc;
    int lat;
    logic [7:0] part;

    rx_pin_in       = 1'b1;
    rx_buf_not_full = 1'b1;
    rst             = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_write", 32'(rx_write_buf), 32'd0);
    check("reset_ferr", 32'(rx_frame_err), 32'd0);
    check("reset_ovr", 32'(rx_overrun), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    repeat (20) @(negedge clk);

    // 1: single byte and its latency
    exp_q.push_back({K_WRITE, 8'hA5});
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    drain("t1_drain", 400);
    // pin effective at posedge fall_cyc+1; strobe produced at posedge last_write_cyc
    lat = last_write_cyc - fall_cyc - 1;
    n_vec++;
    if (lat < 151 || lat > 157) begin
      n_err++;
      $display("FAIL t1_latency: got %0d required 151..157", lat);
    end
    repeat (10) @(negedge clk);

    // 2: back-to-back frames
    exp_q.push_back({K_WRITE, 8'h00});
    exp_q.push_back({K_WRITE, 8'hFF});
    exp_q.push_back({K_WRITE, 8'h01});
    exp_q.push_back({K_WRITE, 8'h80});
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    drain("t2_drain", 400);
    repeat (10) @(negedge clk);

    // 3: three-tick low glitch on an idle line
    rx_pin_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin_in = 1'b1;
    repeat (40) @(negedge clk);
    check("t3_state", 32'(dut.state), 32'(IDLE));

    // 4: framing error, stuck-low line, then recovery
    exp_q.push_back({K_FERR, 8'h00});
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (8 * 16) @(negedge clk);
    check("t4_wait_high", 32'(dut.state), 32'(WAIT_HIGH));
    check("t4_ferr_seen", 32'(exp_q.size()), 32'd0);
    repeat (11 * 16) @(negedge clk);
    rx_pin_in = 1'b1;
    repeat (32) @(negedge clk);
    check("t4_idle", 32'(dut.state), 32'(IDLE));
    exp_q.push_back({K_WRITE, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b1);
    drain("t4_drain", 400);
    repeat (10) @(negedge clk);

    // 5: overrun keeps the previous byte
    exp_q.push_back({K_OVR, 8'h00});
    send_frame(8'h77, 1'b1, 1'b0);
    drain("t5_drain", 400);
    check("t5_data_hold", 32'(rx_data), 32'h5A);
    repeat (10) @(negedge clk);

    // 6: reset during data bit 4
    part = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    rx_pin_in = part[4];
    repeat (8) @(negedge clk);
    rst       = 1'b0;
    rx_pin_in = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_data", 32'(rx_data), 32'h00);
    check("t6_rst_write", 32'(rx_write_buf), 32'd0);
    check("t6_rst_ferr", 32'(rx_frame_err), 32'd0);
    check("t6_rst_ovr", 32'(rx_overrun), 32'd0);
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    exp_q.push_back({K_WRITE, 8'hC3});
    send_frame(8'hC3, 1'b1, 1'b1);
    drain("t6_drain", 400);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
